// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// The index/one-hot mapping matches the 4:2 encoder: 0001->00, 0010->01, 0100->10, 1000->11.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [0:0] {
        IDLE,
        OWN
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request bit at or after ptr_i, wrapping mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down, so the closest set bit to ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr_i + IDX_W'(i);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for 4 requesters with registered grant outputs and a
// maximum-hold preemption that only fires while another requester is waiting.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               others_waiting;

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign others_waiting = |(req & ~gnt_q);

    // gnt_idx_q doubles as the owner register, so the encoded index never depends on gnt decoding.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = OWN;
                    gnt_d       = idx_to_onehot(pick_idx);
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    rr_ptr_d    = pick_idx + IDX_W'(1);
                    hold_cnt_d  = '0;
                end
            end
            OWN: begin
                if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST && others_waiting)) begin
                    // A voluntary drop takes precedence over a coincident timeout.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = req[gnt_idx_q];
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed-vector bench for rr_req_arbiter: reset, single owner, round-robin
// order, preemption, drop on the timeout edge and pointer wrap-around.
module tb_rr_req_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors;
    int miscompares;

    rr_req_arbiter #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got gnt=%b idx=%b v=%b to=%b expected all zero", gnt, gnt_idx, gnt_valid, timeout);
        end
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_grant: got %b expected 0100", gnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got gnt=%b idx=%b v=%b to=%b expected all zero", gnt, gnt_idx, gnt_valid, timeout);
        end
        req = 4'b0001;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'b00 || gnt_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_grant: got gnt=%b idx=%b v=%b expected 0001/00/1", gnt, gnt_idx, gnt_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (gnt !== 4'b0100 || gnt_idx !== 2'b10 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL single_hold c%0d: got gnt=%b idx=%b v=%b to=%b expected 0100/10/1/0", c, gnt, gnt_idx, gnt_valid, timeout);
            end
        end
        req = 4'b0000;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_release: got gnt=%b v=%b expected 0000/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5];
        logic [1:0] idxs  [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        idxs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (gnt !== order[k] || gnt_idx !== idxs[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_grant k%0d: got gnt=%b idx=%b expected %b/%b", k, gnt, gnt_idx, order[k], idxs[k]);
            end
            tick();
            vectors++;
            if (gnt !== order[k]) begin
                miscompares++;
                $display("[TB] FAIL rr_hold k%0d: got %b expected %b", k, gnt, order[k]);
            end
            req = 4'b1111 & ~order[k];
            tick();
            vectors++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_idle k%0d: got gnt=%b v=%b expected 0000/0", k, gnt, gnt_valid);
            end
            req = 4'b1111;
        end
    endtask

    task automatic test_preempt();
        logic [3:0] expg;
        do_reset();
        req = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            expg = (r % 2 == 0) ? 4'b0001 : 4'b0010;
            for (int c = 0; c < 8; c++) begin
                tick();
                vectors++;
                if (gnt !== expg || timeout !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL preempt_own r%0d c%0d: got gnt=%b to=%b expected %b/0", r, c, gnt, timeout, expg);
                end
            end
            tick();
            vectors++;
            if (gnt !== 4'b0000 || timeout !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL preempt_timeout r%0d: got gnt=%b to=%b expected 0000/1", r, gnt, timeout);
            end
        end
    endtask

    task automatic test_drop_on_timeout();
        do_reset();
        req = 4'b0011;
        repeat (8) tick();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL drop_pre: got %b expected 0001", gnt);
        end
        req = 4'b0010;
        tick();
        vectors++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_release: got gnt=%b to=%b expected 0000/0", gnt, timeout);
        end
        tick();
        vectors++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'b01 || timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_next: got gnt=%b idx=%b to=%b expected 0010/01/0", gnt, gnt_idx, timeout);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        vectors++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL wrap_owner3: got gnt=%b idx=%b expected 1000/11", gnt, gnt_idx);
        end
        req = 4'b0001;
        tick();
        req = 4'b1001;
        tick();
        vectors++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL wrap_next: got gnt=%b idx=%b expected 0001/00", gnt, gnt_idx);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        req         = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_drop_on_timeout();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between 4 requesters.
- Produces a registered one-hot grant and its 2-bit encoded index, using the same code mapping as the team's 4:2 encoder: 0001→00, 0010→01, 0100→10, 1000→11.
- Enforces a maximum ownership time so no requester can starve the others.
- Sits between the requester ports and the shared resource's select mux.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 for this revision.
- IDX_W, 2, width of the encoded grant index; equals clog2(NUM_REQ).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others are waiting; legal range ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request level; held high while the requester wants or uses the resource.
- gnt  output  4  one-hot grant; all zero when no owner.
- gnt_idx  output  2  encoded index of the current owner; 00 when no owner.
- gnt_valid  output  1  high when gnt is nonzero.
- timeout  output  1  one-cycle pulse when the owner is preempted by MAX_HOLD.

Behaviour:
- Reset (reset_n low, asynchronous): gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, state=IDLE, rr_ptr=0, hold_cnt=0. Effect is immediate, mid-grant included. First rising edge after release behaves as IDLE.
- All outputs are registered. No combinational path from req to any output.
- States:
  - IDLE: no owner.
  - OWN: owner holds the grant.
- IDLE → OWN:
  - Taken when |req is 1 at a rising edge.
  - Owner = first set bit of req, searching rr_ptr, rr_ptr+1, …, wrapping mod 4.
  - gnt, gnt_idx and gnt_valid are valid from that edge. Latency is 1 cycle from req sampled to grant.
  - rr_ptr ← owner+1 mod 4; hold_cnt ← 0.
- IDLE with req=0000: stays IDLE, outputs unchanged at zero.
- OWN, normal hold:
  - If req[owner]=1 and no preemption applies: stay in OWN, grant unchanged.
  - hold_cnt increments, saturating at MAX_HOLD-1.
- OWN, voluntary release:
  - If req[owner]=0: go to IDLE, clearing gnt, gnt_idx and gnt_valid at that edge.
  - There is always one idle cycle between owners, even when other requests are pending.
- OWN, preemption:
  - Condition: hold_cnt==MAX_HOLD-1, req[owner]=1, and (req & ~gnt)≠0.
  - Go to IDLE, clear the grant, and pulse timeout=1 for exactly one cycle.
  - The next arbitration starts at the already advanced rr_ptr, so the preempted owner has lowest priority.
- OWN with hold_cnt saturated and no other requester: owner keeps the grant indefinitely and timeout stays 0.
- Simultaneous owner drop and timeout condition: treat as voluntary release; timeout=0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx == encode(gnt).
  - gnt_valid == |gnt.
  - An owner never receives back-to-back grants while another requester is continuously waiting.
- The encoded index is formed only from the internal owner register, so an X-producing default case cannot occur.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ and IDX_W constants.
  - typedef enum logic [0:0] {IDLE, OWN} arb_state_t.
  - Function onehot_to_idx (4:2 encode) and function idx_to_onehot.
- Natural sub-module: rr_pick4. Combinational; takes req[3:0] and ptr[1:0]; returns found and idx[1:0]. The top module holds the FSM, rr_ptr, hold_cnt and the output registers.

Test Plan:
- Reset: assert reset_n=0 mid-grant with gnt=0100 → outputs go 0 immediately, without waiting for a clock edge. After release with req=0001 → one cycle later gnt=0001, gnt_idx=00, gnt_valid=1.
- Single requester: req=0100 held for 20 cycles → gnt=0100 and gnt_idx=10 from cycle 1 onward, never preempted, timeout never pulses. Drop req → gnt=0000 next cycle.
- Round-robin order: req=1111 with each owner dropping its req for one cycle after 2 cycles of grant, starting from rr_ptr=0 → grant order 0001, 0010, 0100, 1000, 0001. Exactly one idle cycle between owners.
- Preemption: req=0011 continuously after reset → gnt=0001 for 8 cycles, then timeout=1 with gnt=0000 for one cycle, then gnt=0010 for 8 cycles, alternating.
- Drop on timeout edge: owner 0 drops req exactly when hold_cnt=7 while req[1]=1 → IDLE with timeout=0, then gnt=0010.
- Wrap-around: owner=3 released, req=1001 → next grant 0001 (idx 00), not 1000.
